// File: rtl/rmt_action_pkg.sv
// Shared action-word layout, opcode constants and issue-FSM state type
// for the per-lane ALU issue controllers.
package rmt_action_pkg;

  localparam int IDX_W = 3;
  localparam int OPC_W = 4;
  localparam int IMM_W = 11;

  localparam int OPC_HI  = 24;
  localparam int OPC_LO  = 21;
  localparam int IMM_SEL = 20;
  localparam int OP1_HI  = 19;
  localparam int OP1_LO  = 17;
  localparam int OP2_HI  = 16;
  localparam int OP2_LO  = 14;
  localparam int DST_HI  = 13;
  localparam int DST_LO  = 11;
  localparam int IMM_HI  = 10;
  localparam int IMM_LO  = 0;

  localparam logic [OPC_W-1:0] OP_NOP = 4'b0000;
  localparam logic [OPC_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OPC_W-1:0] OP_SUB = 4'b0010;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } issue_state_t;

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issues one action to an alu_1 lane, waits for its result and writes it back
// into the destination container of the captured PHV.
//
// state | meaning
// IDLE  | ready for a request; captures action, PHV and operands
// ISSUE | one-cycle action_valid_out to the ALU; timeout counter cleared
// WAIT  | waiting for container_in_valid or timeout
// OUT   | PHV presented until phv_out_ready
module alu_issue_ctrl
  import rmt_action_pkg::*;
#(
  parameter int STAGE      = 0,
  parameter int ACTION_LEN = 25,
  parameter int DATA_WIDTH = 48,
  parameter int NUM_CONT   = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [ACTION_LEN-1:0]          req_action,
  input  logic [NUM_CONT*DATA_WIDTH-1:0] req_phv,
  output logic [ACTION_LEN-1:0]          action_out,
  output logic                           action_valid_out,
  output logic [DATA_WIDTH-1:0]          operand_1_out,
  output logic [DATA_WIDTH-1:0]          operand_2_out,
  input  logic [DATA_WIDTH-1:0]          container_in,
  input  logic                           container_in_valid,
  output logic [NUM_CONT*DATA_WIDTH-1:0] phv_out,
  output logic                           phv_out_valid,
  input  logic                           phv_out_ready,
  output logic                           err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  if (ACTION_LEN != 25 || STAGE < 0) begin : g_bad_cfg
    // The action field positions are fixed; other widths cannot decode.
  end

  issue_state_t                  state_q, state_d;
  logic [ACTION_LEN-1:0]         action_q, action_d;
  logic [DATA_WIDTH-1:0]         op1_q, op1_d;
  logic [DATA_WIDTH-1:0]         op2_q, op2_d;
  logic [NUM_CONT*DATA_WIDTH-1:0] phv_q, phv_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0]          req_cont [NUM_CONT];
  logic [NUM_CONT*DATA_WIDTH-1:0] wb_phv;
  logic [IDX_W-1:0]               dst_idx;
  logic [IMM_W-1:0]               req_imm;

  assign dst_idx = action_q[DST_HI:DST_LO];
  assign req_imm = req_action[IMM_HI:IMM_LO];

  always_comb begin
    for (int k = 0; k < NUM_CONT; k++) begin
      req_cont[k] = req_phv[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Write-back image: only the destination container takes the ALU result.
  always_comb begin
    wb_phv = phv_q;
    for (int k = 0; k < NUM_CONT; k++) begin
      if (IDX_W'(k) == dst_idx) begin
        wb_phv[k*DATA_WIDTH +: DATA_WIDTH] = container_in;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    action_d         = action_q;
    op1_d            = op1_q;
    op2_d            = op2_q;
    phv_d            = phv_q;
    cnt_d            = cnt_q;
    req_ready        = 1'b0;
    action_valid_out = 1'b0;
    phv_out_valid    = 1'b0;
    err_timeout      = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          action_d = req_action;
          phv_d    = req_phv;
          op1_d    = req_cont[req_action[OP1_HI:OP1_LO]];
          op2_d    = req_action[IMM_SEL] ? DATA_WIDTH'(req_imm)
                                         : req_cont[req_action[OP2_HI:OP2_LO]];
          state_d  = (req_action[OPC_HI:OPC_LO] == OP_NOP) ? S_OUT : S_ISSUE;
        end
      end

      S_ISSUE: begin
        action_valid_out = 1'b1;
        cnt_d            = '0;
        state_d          = S_WAIT;
      end

      S_WAIT: begin
        if (container_in_valid) begin
          phv_d   = wb_phv;
          state_d = S_OUT;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          err_timeout = 1'b1;
          state_d     = S_OUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_OUT: begin
        phv_out_valid = 1'b1;
        if (phv_out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      action_q <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      phv_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      action_q <= action_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      phv_q    <= phv_d;
      cnt_q    <= cnt_d;
    end
  end

  assign action_out    = action_q;
  assign operand_1_out = op1_q;
  assign operand_2_out = op2_q;
  assign phv_out       = phv_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed and randomized bench for alu_issue_ctrl with a behavioural
// container-array model and a stub ALU lane.
module tb_alu_issue_ctrl;
  import rmt_action_pkg::*;

  localparam int AL  = 25;
  localparam int DW  = 48;
  localparam int NC  = 8;
  localparam int TO  = 15;
  localparam int PW  = NC * DW;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AL-1:0] req_action;
  logic [PW-1:0] req_phv;
  logic [AL-1:0] action_out;
  logic          action_valid_out;
  logic [DW-1:0] operand_1_out;
  logic [DW-1:0] operand_2_out;
  logic [DW-1:0] container_in;
  logic          container_in_valid;
  logic [PW-1:0] phv_out;
  logic          phv_out_valid;
  logic          phv_out_ready;
  logic          err_timeout;

  int total = 0;
  int bad   = 0;

  alu_issue_ctrl #(
    .STAGE(0), .ACTION_LEN(AL), .DATA_WIDTH(DW), .NUM_CONT(NC), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_action(req_action), .req_phv(req_phv),
    .action_out(action_out), .action_valid_out(action_valid_out),
    .operand_1_out(operand_1_out), .operand_2_out(operand_2_out),
    .container_in(container_in), .container_in_valid(container_in_valid),
    .phv_out(phv_out), .phv_out_valid(phv_out_valid),
    .phv_out_ready(phv_out_ready), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AL-1:0] mk_act(input logic [3:0] opc, input logic isel,
                                           input int o1, input int o2, input int d,
                                           input int imm);
    logic [AL-1:0] a;
    a = {opc, isel, 3'(o1), 3'(o2), 3'(d), 11'(imm)};
    return a;
  endfunction

  function automatic logic [PW-1:0] rand_phv();
    logic [PW-1:0] p;
    for (int k = 0; k < NC; k++) p[k*DW +: DW] = {$urandom(), $urandom()} & {DW{1'b1}};
    return p;
  endfunction

  // One full transaction. resp_cyc is the cycle (accept edge = 0) in which the
  // stub ALU raises container_in_valid; 0 means the ALU never answers.
  task automatic run_txn(input logic [AL-1:0] act, input logic [PW-1:0] phv,
                         input int resp_cyc_in, input int hold);
    logic [DW-1:0] c [NC];
    logic [DW-1:0] e1, e2, a, b;
    logic [PW-1:0] exp_phv;
    logic [3:0]    opc;
    int            resp_cyc, last;
    bit            alu_op;

    for (int k = 0; k < NC; k++) c[k] = phv[k*DW +: DW];
    opc      = act[24:21];
    e1       = c[act[19:17]];
    e2       = act[20] ? DW'(act[10:0]) : c[act[16:14]];
    alu_op   = (opc == OP_ADD) || (opc == OP_SUB);
    resp_cyc = alu_op ? resp_cyc_in : 0;
    if (alu_op && resp_cyc != 0)
      c[act[13:11]] = (opc == OP_ADD) ? DW'(e1 + e2) : DW'(e1 - e2);
    for (int k = 0; k < NC; k++) exp_phv[k*DW +: DW] = c[k];

    @(negedge clk);
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_action = act; req_phv = phv;
    @(negedge clk);
    req_valid = 1'b0; req_phv = rand_phv();

    if (opc == OP_NOP) begin
      chk("nop_no_issue", action_valid_out, 1'b0);
      chk("nop_valid_c1", phv_out_valid, 1'b1);
    end else begin
      chk("issue_c1", action_valid_out, 1'b1);
      chk("action_out", action_out, act);
      chk("operand_1", operand_1_out, e1);
      chk("operand_2", operand_2_out, e2);
      chk("no_valid_c1", phv_out_valid, 1'b0);
      a = operand_1_out; b = operand_2_out;
      last = (resp_cyc != 0) ? resp_cyc : TO + 2;
      for (int k = 2; k <= last; k++) begin
        @(negedge clk);
        if (k == resp_cyc) begin
          container_in_valid = 1'b1;
          container_in = (action_out[24:21] == OP_ADD) ? DW'(a + b) : DW'(a - b);
        end
        #1;
        chk("err_timeout", err_timeout, (resp_cyc == 0 && k == TO + 2));
        chk("single_issue", action_valid_out, 1'b0);
        chk("no_early_valid", phv_out_valid, 1'b0);
      end
      @(negedge clk);
      container_in_valid = 1'b0;
      chk("err_after", err_timeout, 1'b0);
    end

    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", phv_out_valid, 1'b1);
      chk("hold_phv", phv_out, exp_phv);
      chk("hold_not_ready", req_ready, 1'b0);
      container_in_valid = 1'b1;
      container_in = {$urandom(), $urandom()} & {DW{1'b1}};
      @(negedge clk);
      container_in_valid = 1'b0;
    end
    chk("out_valid", phv_out_valid, 1'b1);
    chk("out_phv", phv_out, exp_phv);
    phv_out_ready = 1'b1;
    @(negedge clk);
    phv_out_ready = 1'b0;
    chk("single_transfer", phv_out_valid, 1'b0);
    chk("ready_after", req_ready, 1'b1);
  endtask

  initial begin
    logic [PW-1:0] p;
    logic [3:0]    opc;
    int            r;

    rst = 1'b1; req_valid = 1'b0; req_action = '0; req_phv = '0;
    container_in = '0; container_in_valid = 1'b0; phv_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_phv", phv_out, '0);
    chk("rst_valid", phv_out_valid, 1'b0);
    chk("rst_issue", action_valid_out, 1'b0);
    chk("rst_err", err_timeout, 1'b0);
    chk("rst_action", action_out, '0);
    chk("rst_op1", operand_1_out, '0);
    chk("rst_op2", operand_2_out, '0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", req_ready, 1'b1);

    // ADD c0=1 + c1=3 -> c2
    p = rand_phv(); p[0 +: DW] = 48'd1; p[DW +: DW] = 48'd3;
    run_txn(mk_act(OP_ADD, 1'b0, 0, 1, 2, 0), p, 2, 0);
    // SUB with immediate: c0 = 20 - 3
    p = rand_phv(); p[0 +: DW] = 48'd20;
    run_txn(mk_act(OP_SUB, 1'b1, 0, 5, 0, 3), p, 2, 0);
    // illegal opcode, no ALU answer
    run_txn(mk_act(4'b0011, 1'b0, 4, 6, 7, 0), rand_phv(), 0, 0);
    // NOP
    run_txn(mk_act(OP_NOP, 1'b0, 1, 2, 3, 99), rand_phv(), 0, 0);
    // back-pressure with spurious ALU pulses
    run_txn(mk_act(OP_ADD, 1'b0, 3, 3, 3, 0), rand_phv(), 2, 5);
    // result arrives in the last WAIT cycle: result wins, no error
    run_txn(mk_act(OP_SUB, 1'b0, 7, 2, 5, 0), rand_phv(), TO + 2, 0);
    // subtraction underflow wraps at the container width
    p = '0; p[DW +: DW] = 48'd1;
    run_txn(mk_act(OP_SUB, 1'b1, 1, 0, 1, 11'h7FF), p, 2, 1);

    // reset while waiting for the ALU; result shows up afterwards
    @(negedge clk);
    req_valid = 1'b1; req_action = mk_act(OP_ADD, 1'b0, 0, 1, 2, 0); req_phv = rand_phv();
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstw_issue", action_valid_out, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    container_in_valid = 1'b1; container_in = 48'h123456789ABC;
    #1;
    chk("rstw_phv", phv_out, '0);
    chk("rstw_valid", phv_out_valid, 1'b0);
    chk("rstw_issue0", action_valid_out, 1'b0);
    chk("rstw_err", err_timeout, 1'b0);
    chk("rstw_action", action_out, '0);
    chk("rstw_op1", operand_1_out, '0);
    chk("rstw_op2", operand_2_out, '0);
    chk("rstw_ready", req_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      container_in_valid = 1'b0;
      chk("rstw_no_emit", phv_out_valid, 1'b0);
      chk("rstw_phv_zero", phv_out, '0);
    end

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 2)      opc = OP_NOP;
      else if (r < 5) opc = OP_ADD;
      else if (r < 8) opc = OP_SUB;
      else            opc = 4'($urandom_range(3, 15));
      run_txn(mk_act(opc, 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                     $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 2047)),
              rand_phv(),
              ($urandom_range(0, 3) == 0) ? $urandom_range(3, TO + 2) : 2,
              $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
